fifo_ctrl: RTL



---
 rtl/fifo_ctrl_pkg.sv | 28 ++
 rtl/fifo_ptr.sv | 36 +++
 rtl/fifo_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared definitions for the FIFO pointer/flag controller: FSM state encoding,
// default geometry constants and default almost-full/almost-empty thresholds.
// No ports; imported by fifo_ctrl and fifo_ptr.
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

    localparam int DEF_DATA_SIZE = 10;
    localparam int DEF_MAIN_SIZE = 8;
    localparam int DEF_PTR_SIZE  = 3;

    // Almost-empty default: one word left counts as "almost empty"
    localparam int DEF_AE_TH = 1;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        INIT   = 2'd1,
        IDLE   = 2'd2,
        ACTIVE = 2'd3
    } fifo_state_t;

    // Almost-full default sits one word below the full depth
    function automatic int default_af_th(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Wrap-around pointer register used for both the write and read addresses of
// the FIFO storage array. Wraps naturally modulo 2**PTR_SIZE.
// Ports:
//   clk    - clock, pointer advances on posedge
//   reset  - asynchronous active-low reset, forces pointer to 0
//   clear  - synchronous clear to 0 (has priority over en)
//   en     - advance pointer by one
//   ptr    - current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int PTR_SIZE = DEF_PTR_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                en,
    output logic [PTR_SIZE-1:0] ptr
);

    // Pointer register: clear wins over increment so that a re-initialisation
    // discards any strobe issued in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + PTR_SIZE'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Pointer/flag controller for a FIFO storage array. Turns producer push and
// consumer pop requests into write/read strobes and addresses, tracks
// occupancy, decodes full/empty/almost flags against thresholds latched in the
// INIT state, and raises a sticky error on overflow or underflow.
// Ports:
//   clk           - clock
//   reset         - asynchronous active-low reset
//   init          - return to INIT, latch af_th/ae_th, clear pointers/count/error
//   push, pop     - producer write / consumer read requests
//   af_th, ae_th  - almost-full / almost-empty thresholds
//   write, read   - strobes to the storage array (combinational)
//   wr_ptr,rd_ptr - storage addresses
//   count         - occupancy 0..MAIN_SIZE
//   full, empty, almost_full, almost_empty - status flags from registered count
//   error         - sticky overflow/underflow
//   state         - FSM state for debug
//   hwm           - high-water mark (only when FIFO_HWM_EN is defined)
// Optional feature macro: FIFO_HWM_EN
// -----------------------------------------------------------------------------
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int MAIN_SIZE = DEF_MAIN_SIZE,
    parameter int PTR_SIZE  = DEF_PTR_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic                push,
    input  logic                pop,
    input  logic [PTR_SIZE:0]   af_th,
    input  logic [PTR_SIZE:0]   ae_th,
    output logic                write,
    output logic                read,
    output logic [PTR_SIZE-1:0] wr_ptr,
    output logic [PTR_SIZE-1:0] rd_ptr,
    output logic [PTR_SIZE:0]   count,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                error,
    output logic [1:0]          state
`ifdef FIFO_HWM_EN
    ,
    output logic [PTR_SIZE:0]   hwm
`endif
);

    localparam logic [PTR_SIZE:0] FULL_COUNT = (PTR_SIZE+1)'(MAIN_SIZE);
    localparam logic [PTR_SIZE:0] ONE_COUNT  = (PTR_SIZE+1)'(1);
    localparam logic [PTR_SIZE:0] RESET_AF   = (PTR_SIZE+1)'(default_af_th(MAIN_SIZE));
    localparam logic [PTR_SIZE:0] RESET_AE   = (PTR_SIZE+1)'(DEF_AE_TH);

    // A non-power-of-two depth or an empty data word cannot work with natural
    // pointer wrap; such a build shows up as g_bad_config in the hierarchy
    generate
        if (DATA_SIZE < 1 || MAIN_SIZE != (1 << PTR_SIZE)) begin : g_bad_config
        end
    endgenerate

    fifo_state_t       state_q;
    fifo_state_t       state_d;
    logic [PTR_SIZE:0] count_q;
    logic [PTR_SIZE:0] count_d;
    logic [PTR_SIZE:0] af_q;
    logic [PTR_SIZE:0] ae_q;
    logic              error_q;
    logic              operating;
    logic              clear_all;
    logic              overflow;
    logic              underflow;

    // Requests only take effect in IDLE/ACTIVE; RESET and INIT hold everything
    // cleared, and an init request from IDLE/ACTIVE clears on the same edge
    assign operating = (state_q == IDLE) || (state_q == ACTIVE);
    assign clear_all = ~operating | init;

    // Flags come from the registered count, so they lag the causing edge
    assign full         = (count_q == FULL_COUNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_q);
    assign almost_empty = (count_q <= ae_q);

    // A push into a full FIFO is still allowed when a pop frees the slot in
    // the same cycle; a pop from an empty FIFO is never allowed
    assign write     = operating & push & (~full | pop);
    assign read      = operating & pop & ~empty;
    assign overflow  = operating & push & full & ~pop;
    assign underflow = operating & pop & empty;

    assign count = count_q;
    assign error = error_q;
    assign state = state_q;

    // Next occupancy: simultaneous write and read cancel out
    always_comb begin
        count_d = count_q;
        if (write && !read) begin
            count_d = count_q + ONE_COUNT;
        end else if (read && !write) begin
            count_d = count_q - ONE_COUNT;
        end
    end

    // Next-state logic: IDLE/ACTIVE follow the occupancy the FIFO will have
    // after this edge, init always pulls back to INIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:   state_d = INIT;
            INIT:    if (!init) state_d = IDLE;
            IDLE,
            ACTIVE: begin
                if (init) begin
                    state_d = INIT;
                end else if (count_d == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: state_d = RESET;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy, sticky error and threshold latches. Thresholds are sampled
    // every INIT cycle so the value present when init drops is the one kept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            error_q <= 1'b0;
            af_q    <= RESET_AF;
            ae_q    <= RESET_AE;
        end else begin
            if (clear_all) begin
                count_q <= '0;
                error_q <= 1'b0;
            end else begin
                count_q <= count_d;
                if (overflow || underflow) begin
                    error_q <= 1'b1;
                end
            end
            if (state_q == INIT) begin
                af_q <= af_th;
                ae_q <= ae_th;
            end
        end
    end

    fifo_ptr #(
        .PTR_SIZE (PTR_SIZE)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (clear_all),
        .en    (write),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(
        .PTR_SIZE (PTR_SIZE)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (clear_all),
        .en    (read),
        .ptr   (rd_ptr)
    );

`ifdef FIFO_HWM_EN
    logic [PTR_SIZE:0] hwm_q;

    // High-water mark tracks the largest occupancy reached since the last
    // reset or re-initialisation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hwm_q <= '0;
        end else if (clear_all) begin
            hwm_q <= '0;
        end else if (count_d > hwm_q) begin
            hwm_q <= count_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule
